// File: rtl/key_space_scheduler_pkg.sv
// Shared types and constants for the RC4 key-space scheduler.
package rc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } sched_state_t;

    localparam int unsigned KEY_WIDTH_DEFAULT = 24;

    localparam int unsigned LED_WIDTH     = 10;
    localparam int unsigned LED_FOUND     = 0;
    localparam int unsigned LED_EXHAUSTED = 1;
    localparam int unsigned LED_BUSY      = 2;

    // Index width for n cores; a single core still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_space_scheduler_if.sv
// Scheduler-to-core handshake bundle: launches, aborts and per-core results.
interface key_space_scheduler_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned KEY_WIDTH = 24
) ();

    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic [NUM_CORES-1:0]           core_abort;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES-1:0]           core_valid;

    modport master (
        output core_start, core_key, core_abort,
        input  core_done, core_valid
    );

    modport slave (
        input  core_start, core_key, core_abort,
        output core_done, core_valid
    );

endinterface

// File: rtl/key_space_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import rc4_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    int unsigned idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = PW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_space_scheduler.sv
// Hands RC4 key candidates to parallel cracking cores, tracks in-flight work
// and stops on the first valid decrypt or when the key space runs out.
module key_space_scheduler
    import rc4_pkg::*;
#(
    parameter int unsigned           NUM_CORES = 4,
    parameter int unsigned           KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0]  KEY_LAST  = {KEY_WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    key_space_scheduler_if.master     cores,
    output logic                      busy,
    output logic                      found,
    output logic                      exhausted,
    output logic [KEY_WIDTH-1:0]      found_key,
    output logic [LED_WIDTH-1:0]      LEDR
);

    localparam int unsigned PW = ptr_width(NUM_CORES);
    localparam logic [KEY_WIDTH:0] KEY_LAST_EXT = {1'b0, KEY_LAST};
    localparam logic [KEY_WIDTH:0] KEY_ONE      = 1;

    sched_state_t           state;
    logic [KEY_WIDTH:0]     next_key;
    logic [NUM_CORES-1:0]   in_flight;
    logic [PW-1:0]          rr_ptr;
    logic [KEY_WIDTH-1:0]   key_reg [NUM_CORES];

    logic [NUM_CORES-1:0]   done_hit;
    logic [NUM_CORES-1:0]   valid_hit;
    logic [NUM_CORES-1:0]   grant;
    logic [PW-1:0]          grant_idx;
    logic                   grant_valid;
    logic [PW-1:0]          rr_next;
    logic                   win_any;
    logic [KEY_WIDTH-1:0]   win_key;

    assign done_hit  = cores.core_done & in_flight;
    assign valid_hit = done_hit & cores.core_valid;
    assign rr_next   = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req         (~in_flight),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Same-cycle valid completions resolve to the numerically smallest key.
    always_comb begin
        win_any = 1'b0;
        win_key = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (valid_hit[i] && (!win_any || key_reg[i] < win_key)) begin
                win_any = 1'b1;
                win_key = key_reg[i];
            end
        end
    end

    always_comb begin
        cores.core_key = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cores.core_key[i*KEY_WIDTH +: KEY_WIDTH] = key_reg[i];
        end
    end

    always_comb begin
        LEDR                = '0;
        LEDR[LED_FOUND]     = found;
        LEDR[LED_EXHAUSTED] = exhausted;
        LEDR[LED_BUSY]      = busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            next_key         <= '0;
            in_flight        <= '0;
            rr_ptr           <= '0;
            key_reg          <= '{default: '0};
            cores.core_start <= '0;
            cores.core_abort <= '0;
            busy             <= 1'b0;
            found            <= 1'b0;
            exhausted        <= 1'b0;
            found_key        <= '0;
        end else begin
            cores.core_start <= '0;
            cores.core_abort <= '0;
            case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    // Key 0 launches on the start edge itself; in_flight is empty here.
                    if (start) begin
                        found               <= 1'b0;
                        exhausted           <= 1'b0;
                        found_key           <= '0;
                        busy                <= 1'b1;
                        cores.core_start    <= grant;
                        key_reg[grant_idx]  <= '0;
                        in_flight           <= grant;
                        next_key            <= KEY_ONE;
                        rr_ptr              <= rr_next;
                        state               <= (KEY_LAST_EXT == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (abort) begin
                        cores.core_abort <= in_flight & ~done_hit;
                        in_flight        <= '0;
                        busy             <= 1'b0;
                        state            <= ST_IDLE;
                    end else if (win_any) begin
                        found            <= 1'b1;
                        found_key        <= win_key;
                        cores.core_abort <= in_flight & ~done_hit;
                        in_flight        <= '0;
                        busy             <= 1'b0;
                        state            <= ST_FOUND;
                    end else if (state == ST_DRAIN) begin
                        in_flight <= in_flight & ~done_hit;
                        if (in_flight == '0) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_EXHAUSTED;
                        end
                    end else if (grant_valid) begin
                        cores.core_start   <= grant;
                        key_reg[grant_idx] <= next_key[KEY_WIDTH-1:0];
                        in_flight          <= (in_flight & ~done_hit) | grant;
                        next_key           <= next_key + KEY_ONE;
                        rr_ptr             <= rr_next;
                        if (next_key >= KEY_LAST_EXT) begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        in_flight <= in_flight & ~done_hit;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_space_scheduler.sv
// Randomized scoreboard bench: behavioural cores feed the scheduler, a monitor
// checks every dispatch and every terminal result against queued expectations.
module tb_key_space_scheduler;
    import rc4_pkg::*;

    localparam int unsigned NC    = 4;
    localparam int unsigned KW    = 24;
    localparam int unsigned NKEYS = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic           busy;
    logic           found;
    logic           exhausted;
    logic [KW-1:0]  found_key;
    logic [9:0]     LEDR;

    key_space_scheduler_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) cif ();

    key_space_scheduler #(
        .NUM_CORES (NC),
        .KEY_WIDTH (KW),
        .KEY_LAST  (24'd63)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cores     (cif),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .found_key (found_key),
        .LEDR      (LEDR)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural core farm
    bit          r_busy [NC];
    int unsigned r_key  [NC];
    int unsigned r_cnt  [NC];
    bit          valid_key [NKEYS];
    bit          hold_key  [NKEYS];
    int unsigned hold_total = 0;
    bit          freeze     = 1'b0;
    bit          spurious   = 1'b0;

    function automatic logic [NC-1:0] r_mask();
        logic [NC-1:0] m;
        for (int unsigned i = 0; i < NC; i++) m[i] = r_busy[i];
        return m;
    endfunction

    always @(negedge clk) begin
        logic [NC-1:0] d;
        logic [NC-1:0] v;
        int unsigned   held;
        d = '0;
        v = '0;
        if (reset) begin
            for (int unsigned i = 0; i < NC; i++) r_busy[i] = 1'b0;
        end else begin
            for (int unsigned i = 0; i < NC; i++)
                if (cif.core_abort[i]) r_busy[i] = 1'b0;
            for (int unsigned i = 0; i < NC; i++) begin
                if (cif.core_start[i]) begin
                    check("start_on_free_core", 64'(r_busy[i]), 64'd0);
                    r_busy[i] = 1'b1;
                    r_key[i]  = int'(cif.core_key[i*KW +: KW]) % NKEYS;
                    r_cnt[i]  = $urandom_range(0, 5);
                end
            end
            held = 0;
            for (int unsigned i = 0; i < NC; i++)
                if (r_busy[i] && hold_key[r_key[i]]) held++;
            for (int unsigned i = 0; i < NC; i++) begin
                if (r_busy[i] && !freeze) begin
                    if (hold_key[r_key[i]] ? (held == hold_total) : (r_cnt[i] == 0)) begin
                        d[i]      = 1'b1;
                        v[i]      = valid_key[r_key[i]];
                        r_busy[i] = 1'b0;
                    end else if (r_cnt[i] != 0) begin
                        r_cnt[i]--;
                    end
                end
            end
            if (spurious)
                for (int unsigned i = 0; i < NC; i++)
                    if (!r_busy[i] && !d[i] && $urandom_range(0, 7) == 0) begin
                        d[i] = 1'b1;
                        v[i] = 1'b1;
                    end
        end
        cif.core_done  = d;
        cif.core_valid = v;
    end

    // Scoreboard
    typedef struct { bit f; bit e; int unsigned k; } res_t;
    int unsigned exp_key_q [$];
    res_t        exp_res_q [$];
    int unsigned log_core  [$];
    int          log_cyc   [$];
    int unsigned n_disp    = 0;
    bit          terminal  = 1'b0;
    bit          prev_flag = 1'b0;

    always @(posedge clk) begin
        res_t r;
        #1;
        if (reset) begin
            prev_flag = 1'b0;
        end else begin
            for (int unsigned i = 0; i < NC; i++) begin
                if (cif.core_start[i]) begin
                    n_disp++;
                    log_core.push_back(i);
                    log_cyc.push_back(cyc);
                    check("start_after_result", 64'(terminal), 64'd0);
                    if (exp_key_q.size() == 0)
                        check("dispatch_extra_key", 64'(cif.core_key[i*KW +: KW]), 64'hFFFF_FFFF);
                    else
                        check("dispatch_key", 64'(cif.core_key[i*KW +: KW]), 64'(exp_key_q.pop_front()));
                end
            end
            if ((found || exhausted) && !prev_flag) begin
                terminal = 1'b1;
                if (exp_res_q.size() == 0) begin
                    check("unexpected_result", {62'd0, found, exhausted}, 64'd0);
                end else begin
                    r = exp_res_q.pop_front();
                    check("found_flag", 64'(found), 64'(r.f));
                    check("exhausted_flag", 64'(exhausted), 64'(r.e));
                    check("busy_at_result", 64'(busy), 64'd0);
                    check("ledr_at_result", 64'(LEDR), {61'd0, 1'b0, r.e, r.f});
                    check("abort_mask_at_result", 64'(cif.core_abort), 64'(r_mask()));
                    if (r.f) check("found_key", 64'(found_key), 64'(r.k));
                end
            end
            prev_flag = found || exhausted;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        exp_key_q.delete();
        for (int unsigned k = 0; k < NKEYS; k++) exp_key_q.push_back(k);
        log_core.delete();
        log_cyc.delete();
        n_disp   = 0;
        terminal = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        for (int c = 0; c < budget && exp_res_q.size() != 0; c++) @(negedge clk);
        check("result_timeout", 64'(exp_res_q.size()), 64'd0);
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mask", 64'(cif.core_abort), 64'(r_mask()));
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_found", 64'(found), 64'd0);
        check("abort_exhausted", 64'(exhausted), 64'd0);
        check("abort_ledr", 64'(LEDR), 64'd0);
    endtask

    task automatic set_keys(input int unsigned v0, input int unsigned v1, input bit hold);
        for (int unsigned k = 0; k < NKEYS; k++) begin
            valid_key[k] = 1'b0;
            hold_key[k]  = 1'b0;
        end
        if (v0 < NKEYS) begin valid_key[v0] = 1'b1; hold_key[v0] = hold; end
        if (v1 < NKEYS) begin valid_key[v1] = 1'b1; hold_key[v1] = hold; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cs;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_keys(NKEYS, NKEYS, 1'b0);
        @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_flags", {62'd0, found, exhausted}, 64'd0);
        check("reset_core_key", 64'(cif.core_key), 64'd0);
        check("reset_ledr", 64'(LEDR), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin dispatch order with no completions, then abort.
        freeze = 1'b1;
        pulse_start();
        cs = cyc - 1;
        repeat (8) @(negedge clk);
        check("order_count", 64'(n_disp), 64'd4);
        for (int unsigned j = 0; j < 4 && j < log_core.size(); j++) begin
            check("order_core", 64'(log_core[j]), 64'(j));
            check("order_cycle", 64'(log_cyc[j]), 64'(cs + 1 + j));
        end
        check("order_busy", 64'(busy), 64'd1);
        do_abort();
        freeze = 1'b0;

        // Full sweep with no valid key; spurious done pulses must be ignored.
        spurious = 1'b1;
        exp_res_q.push_back('{f: 1'b0, e: 1'b1, k: 0});
        pulse_start();
        wait_result(3000);
        repeat (5) @(negedge clk);
        check("exhaust_dispatch_count", 64'(n_disp), 64'(NKEYS));
        check("exhaust_keys_left", 64'(exp_key_q.size()), 64'd0);
        check("exhaust_ledr", 64'(LEDR), 64'b10);

        // Single valid key.
        set_keys(42, NKEYS, 1'b0);
        exp_res_q.push_back('{f: 1'b1, e: 1'b0, k: 42});
        pulse_start();
        wait_result(3000);
        repeat (10) @(negedge clk);
        check("found_hold_key", 64'(found_key), 64'd42);

        // Keys 9 and 7 complete valid in the same cycle.
        set_keys(9, 7, 1'b1);
        hold_total = 2;
        exp_res_q.push_back('{f: 1'b1, e: 1'b0, k: 7});
        pulse_start();
        wait_result(3000);
        repeat (5) @(negedge clk);

        // Abort mid-run, restart from key 0, park in DRAIN, then reset.
        set_keys(NKEYS, NKEYS, 1'b0);
        pulse_start();
        repeat ($urandom_range(5, 20)) @(negedge clk);
        do_abort();
        set_keys(NKEYS, NKEYS, 1'b0);
        hold_key[63] = 1'b1;
        pulse_start();
        for (int c = 0; c < 3000 && n_disp < NKEYS; c++) @(negedge clk);
        check("drain_dispatch_count", 64'(n_disp), 64'(NKEYS));
        repeat (4) @(negedge clk);
        check("drain_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_flags", {62'd0, found, exhausted}, 64'd0);
        check("async_reset_start", 64'(cif.core_start), 64'd0);
        check("async_reset_abort", 64'(cif.core_abort), 64'd0);
        check("async_reset_core_key", 64'(cif.core_key), 64'd0);
        check("async_reset_found_key", 64'(found_key), 64'd0);
        check("async_reset_ledr", 64'(LEDR), 64'd0);
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        hold_key[63] = 1'b0;
        hold_total = 0;

        // After reset the pointer restarts at core 0 with key 0.
        freeze = 1'b1;
        pulse_start();
        repeat (3) @(negedge clk);
        check("post_reset_first_core", 64'(log_core.size() > 0 ? log_core[0] : 99), 64'd0);
        do_abort();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
